spi_slave_ctrl: RTL and testbench
=================================

// Module: spi_slave_ctrl
// PURPOSE
//  SPI slave front end: deserialises MOSI frames into 10-bit {cmd,payload} words
//  for the single-port RAM and serialises RAM read data onto MISO.
//  Sits directly upstream of the RAM (drives rx_data/rx_valid) and consumes its
//  dout/tx_valid. Together with the RAM it forms the SPI wrapper.
// PARAMETERS
//  DATA_W   8   payload/address width; frame width FRAME_W = DATA_W+2
// PORTS
//  clk       in   1        system clock; all logic on rising edge
//  rst_n     in   1        reset, asynchronous, active-low
//  SS_n      in   1        slave select, active-low; high = frame end/abort
//  MOSI      in   1        serial data in, MSB first, sampled on rising clk
//  MISO      out  1        serial data out (registered)
//  rx_data   out  FRAME_W  {cmd[1:0], payload[DATA_W-1:0]} to RAM
//  rx_valid  out  1        1-cycle strobe, rx_data valid
//  tx_data   in   DATA_W   RAM read data
//  tx_valid  in   1        RAM read data valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, MISO=0, rx_data=0, rx_valid=0,
//   bit counter=0, rd_addr_seen=0.
//  Commands (rx_data[9:8]): 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
//  - IDLE: SS_n=0 -> CHK_CMD next cycle.
//  - CHK_CMD: sample MOSI as frame bit 9. MOSI=0 -> WRITE;
//    MOSI=1 -> READ_ADD if rd_addr_seen=0, else READ_DATA.
//  - WRITE/READ_ADD/READ_DATA: shift in remaining 9 bits MSB first, one per cycle.
//    Cycle of 9th bit: register full frame to rx_data; rx_valid=1 for exactly
//    the following cycle. Bits are forwarded unmodified (bit 8 from master).
//  - Frame ends: WRITE/READ_ADD wait in state until SS_n=1 -> IDLE; further MOSI
//    ignored, no second rx_valid. READ_ADD completion sets rd_addr_seen=1.
//  - READ_DATA after rx_valid: wait for tx_valid. Cycle tx_valid=1 sampled: load
//    tx_data into shift reg, clear rd_addr_seen. Next 8 cycles MISO drives
//    tx_data[7],..,tx_data[0]; then MISO=0, hold until SS_n=1 -> IDLE.
//    tx_valid seen outside this wait window is ignored.
//  - SS_n=1 in any non-IDLE state -> IDLE next cycle: partial frame discarded,
//    no rx_valid, MISO=0, counter cleared, rd_addr_seen unchanged (unless the
//    load already happened).
//  - SS_n=1 on the same cycle as the 9th bit: frame is still valid; rx_valid fires.
//  - MISO=0 whenever not shifting read data.
//  - Latency: last MOSI bit sampled at edge N -> rx_valid high in cycle N+1.
//  - Counter: 4 bits, saturates; no wrap inside a frame.
// STRUCTURE
//  - spi_pkg: state_e enum; CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA
//    2-bit constants; FRAME_W derivation.
//  - Sub-module spi_shift_reg: parameterised width, serial-in/parallel-out for
//    MOSI and parallel-in/serial-out for MISO. Instantiated twice.
//  - FSM, counter and rd_addr_seen stay in this module.
// TESTING
//  1. Frame 00_0000_0101 -> rx_data=10'h005, one-cycle rx_valid, MISO stays 0.
//  2. Frame 01_1010_1010 -> rx_data=10'h1AA, one-cycle rx_valid.
//  3. Frame rd-addr 10_0000_0101, then rd-data 11_xxxx_xxxx, then tx_valid with
//     tx_data=8'hAA -> MISO 1,0,1,0,1,0,1,0 over 8 cycles; rd_addr_seen cleared.
//  4. SS_n raised after 5 bits -> no rx_valid, state IDLE; next full frame decodes
//     correctly.
//  5. rst_n pulled low mid READ_DATA shift -> all outputs 0 immediately (async);
//     rd_addr_seen=0, so the next read frame enters READ_ADD.
//  6. Second rd-data frame without a new rd-addr -> routed to READ_ADD, no MISO
//     shifting.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared types and constants for the SPI slave front end:
//             FSM state encoding, 2-bit command codes and the frame-width
//             derivation used by the controller and its shift registers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // Command field, carried in the two MSBs of every frame.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    // A frame is the 2-bit command followed by the payload.
    function automatic int frame_w(input int data_w);
        return data_w + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_shift_reg
//  Purpose  : Generic MSB-first shift register. Used serial-in/parallel-out
//             to assemble MOSI frames and parallel-in/serial-out to drive
//             MISO. The serial output is its own flop so it can feed a pin.
//  Ports    : clk, rst_n       clock, async active-low reset
//             clr              synchronous clear (highest priority)
//             load, load_data  parallel load; MSB appears on serial_out next
//             shift, serial_in shift left by one, serial_in enters the LSB
//             par_out          register contents
//             serial_out       registered serial output
//  Revision : 1.0 - initial release
// ============================================================================
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] par_out,
    output logic             serial_out
);

    logic [WIDTH-1:0] r_data;
    logic             r_sout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_sout <= 1'b0;
        end else if (clr) begin
            r_data <= '0;
            r_sout <= 1'b0;
        end else if (load) begin
            // The MSB goes straight to the output flop so the first bit is
            // visible the cycle after the load; the rest queue up behind it.
            r_sout <= load_data[WIDTH-1];
            r_data <= {load_data[WIDTH-2:0], serial_in};
        end else if (shift) begin
            r_sout <= r_data[WIDTH-1];
            r_data <= {r_data[WIDTH-2:0], serial_in};
        end
    end

    assign par_out    = r_data;
    assign serial_out = r_sout;

endmodule
`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_ctrl
//  Purpose  : SPI slave front end. Deserialises MOSI frames into
//             {cmd[1:0], payload} words for the RAM and serialises RAM read
//             data back onto MISO.
//  Ports    : clk, rst_n   system clock, async active-low reset
//             SS_n         slave select, active-low (high ends/aborts frame)
//             MOSI         serial data in, MSB first
//             MISO         serial data out (registered)
//             rx_data      assembled frame to the RAM
//             rx_valid     one-cycle strobe qualifying rx_data
//             tx_data      RAM read data
//             tx_valid     RAM read data valid
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      SS_n,
    input  logic                      MOSI,
    output logic                      MISO,
    output logic [frame_w(DATA_W)-1:0] rx_data,
    output logic                      rx_valid,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_valid
);

    localparam int FRAME_W = frame_w(DATA_W);

    // Bit counter values: last frame bit about to be sampled / frame complete.
    localparam logic [3:0] c_cnt_last = 4'(FRAME_W - 1);
    localparam logic [3:0] c_cnt_full = 4'(FRAME_W);

    state_e               r_state;
    logic [3:0]           r_cnt;
    logic [FRAME_W-1:0]   r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rd_addr_seen;
    logic                 r_loaded;

    logic                 w_rx_clr;
    logic                 w_rx_shift;
    logic [FRAME_W-1:0]   w_rx_par;
    logic                 w_unused_rx_sout;

    logic                 w_tx_clr;
    logic                 w_tx_load;
    logic                 w_tx_shift;
    logic [DATA_W-1:0]    w_unused_tx_par;

    // ------------------------------------------------------------------
    // Shift-register control
    // ------------------------------------------------------------------
    always_comb begin
        w_rx_clr   = (r_state == IDLE);
        // Garbage shifted in after an abort is harmless: IDLE clears it and
        // rx_data only updates on a completed frame.
        w_rx_shift = (r_state != IDLE) && (r_cnt < c_cnt_full);

        // Read data is accepted once per READ_DATA frame, only after the
        // command frame has been fully received.
        w_tx_load  = (r_state == READ_DATA) && (r_cnt == c_cnt_full) &&
                     !r_loaded && !SS_n && tx_valid;
        // Keep shifting after the byte is out so zeros follow on MISO.
        w_tx_shift = r_loaded;
        w_tx_clr   = (r_state != READ_DATA) || SS_n;
    end

    spi_shift_reg #(
        .WIDTH (FRAME_W)
    ) u_rx_sreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_rx_clr),
        .load       (1'b0),
        .shift      (w_rx_shift),
        .serial_in  (MOSI),
        .load_data  ('0),
        .par_out    (w_rx_par),
        .serial_out (w_unused_rx_sout)
    );

    spi_shift_reg #(
        .WIDTH (DATA_W)
    ) u_tx_sreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_tx_clr),
        .load       (w_tx_load),
        .shift      (w_tx_shift),
        .serial_in  (1'b0),
        .load_data  (tx_data),
        .par_out    (w_unused_tx_par),
        .serial_out (MISO)
    );

    // ------------------------------------------------------------------
    // Frame FSM, bit counter and read-address tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_loaded       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt    <= '0;
                    r_loaded <= 1'b0;
                    if (!SS_n) begin
                        r_state <= CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    if (SS_n) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= 4'd1;
                        // Bit 9 splits writes from reads; a read goes to
                        // READ_DATA only once an address has been delivered.
                        if (MOSI == CMD_RD_ADDR[1]) begin
                            r_state <= r_rd_addr_seen ? READ_DATA : READ_ADD;
                        end else begin
                            r_state <= WRITE;
                        end
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    // The final bit completes the frame even if SS_n rises
                    // on this same cycle.
                    if (r_cnt == c_cnt_last) begin
                        r_rx_data  <= {w_rx_par[FRAME_W-2:0], MOSI};
                        r_rx_valid <= 1'b1;
                        if (r_state == READ_ADD) begin
                            r_rd_addr_seen <= 1'b1;
                        end
                    end
                    if (r_cnt < c_cnt_full) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                    if (w_tx_load) begin
                        r_loaded       <= 1'b1;
                        r_rd_addr_seen <= 1'b0;
                    end
                    if (SS_n) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_ctrl
//  Purpose  : Self-checking bench for spi_slave_ctrl. A transaction-level
//             model predicts which frames produce an rx_valid (and when),
//             whether a read returns data on MISO, and the rd-address
//             bookkeeping; directed cases are followed by random frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_ctrl;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    spi_slave_ctrl #(
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [9:0] data;
    } rx_ev_t;

    rx_ev_t got_q[$];
    rx_ev_t exp_q[$];

    int cyc       = 0;
    int total     = 0;
    int bad       = 0;
    int miso_viol = 0;
    bit miso_win  = 1'b0;
    bit m_seen    = 1'b0;   // model: a read address has been delivered

    always @(posedge clk) cyc <= cyc + 1;

    // Record every rx strobe with its cycle number; flag MISO activity
    // outside windows where the bench expects read data.
    always @(negedge clk) begin
        if (rx_valid) got_q.push_back('{cyc, rx_data});
        if (MISO && !miso_win) miso_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_rx();
        check("rx_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("rx_cycle", 32'(got_q[i].cyc), 32'(exp_q[i].cyc));
            check("rx_data", 32'(got_q[i].data), 32'(exp_q[i].data));
        end
        check("miso_idle", 32'(miso_viol), 32'd0);
        got_q.delete();
        exp_q.delete();
        miso_viol = 0;
    endtask

    // One SPI transaction. nbits < 10 aborts after that many frame bits;
    // ss_last raises SS_n together with the final bit.
    task automatic do_frame(input logic [9:0] f, input int nbits, input bit ss_last,
                            input logic [7:0] rd_byte, input int tx_dly);
        bit full;
        bit rd_data_path;
        full         = (nbits == 10);
        rd_data_path = f[9] && m_seen;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            MOSI     = f[9-i];
            tx_valid = 1'($urandom);     // not in the accept window: ignored
            tx_data  = 8'($urandom);
            if (ss_last && i == nbits - 1) SS_n = 1'b1;
        end
        if (full) begin
            exp_q.push_back('{cyc + 1, f});
            if (f[9] && !m_seen) m_seen = 1'b1;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        MOSI     = 1'($urandom);
        if (!full) begin
            SS_n = 1'b1;
        end else if (!ss_last) begin
            repeat (tx_dly) begin
                @(negedge clk);
                MOSI = 1'($urandom);
            end
            tx_data  = rd_byte;
            tx_valid = 1'b1;
            if (rd_data_path) miso_win = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            if (rd_data_path) begin
                for (int b = 7; b >= 0; b--) begin
                    check("miso_bit", 32'(MISO), 32'(rd_byte[b]));
                    @(negedge clk);
                    MOSI = 1'($urandom);
                end
                check("miso_tail", 32'(MISO), 32'd0);
                miso_win = 1'b0;
                m_seen   = 1'b0;
            end else begin
                repeat (9) @(negedge clk);
            end
            // A late tx_valid after the transfer must not restart MISO.
            tx_valid = 1'b1;
            tx_data  = 8'hFF;
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (2) @(negedge clk);
            SS_n = 1'b1;
        end
        repeat (2) @(negedge clk);
        compare_rx();
    endtask

    logic [9:0] f;
    int         nb;
    bit         sl;

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_miso", 32'(MISO), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write frames
        do_frame(10'h005, 10, 1'b0, 8'h5A, 2);
        do_frame(10'h1AA, 10, 1'b0, 8'hC3, 3);

        // Read address, then read data returning 0xAA on MISO
        do_frame(10'h205, 10, 1'b0, 8'h00, 2);
        do_frame({2'b11, 8'h3F}, 10, 1'b0, 8'hAA, 3);

        // Read-data command again without a fresh address: treated as address
        do_frame({2'b11, 8'h81}, 10, 1'b0, 8'hFF, 2);

        // Abort after 5 bits, then a clean frame
        do_frame(10'h1C3, 5, 1'b0, 8'h00, 2);
        do_frame(10'h0C3, 10, 1'b0, 8'h00, 2);

        // SS_n rising with the final bit still completes the frame
        do_frame(10'h15A, 10, 1'b1, 8'h00, 2);
        do_frame({2'b11, 8'h42}, 10, 1'b1, 8'h00, 2);

        // Asynchronous reset in the middle of a MISO transfer
        if (!m_seen) do_frame({2'b10, 8'h11}, 10, 1'b0, 8'h00, 2);
        f = {2'b11, 8'h3C};
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            MOSI = f[9-i];
        end
        exp_q.push_back('{cyc + 1, f});
        @(negedge clk);
        @(negedge clk);
        miso_win = 1'b1;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("rst_pre_miso", 32'(MISO), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        m_seen = 1'b0;
        SS_n   = 1'b1;
        @(negedge clk);
        miso_win = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        compare_rx();
        // Address flag was cleared by reset: this read is an address frame
        do_frame({2'b10, 8'h77}, 10, 1'b0, 8'hC3, 2);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            f  = 10'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 10;
            sl = (nb == 10) && ($urandom_range(0, 4) == 0);
            do_frame(f, nb, sl, 8'($urandom), int'($urandom_range(2, 5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
